// File: rtl/lkup_tbl_ctrl.sv
// Lookup-table RAM controller: arbitrates RAM port A between config writes and the
// table-clear engine, and sequences port-B lookups. Optional macro: LKUP_WR_BYPASS_EN.
module lkup_tbl_ctrl #(
  parameter int unsigned          ADDR_BITS = 5,
  parameter int unsigned          DATA_BITS = 193,
  parameter int unsigned          RD_LAT    = 1,
  parameter logic [DATA_BITS-1:0] CLR_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 cfg_wr_valid,
  input  logic [ADDR_BITS-1:0] cfg_wr_addr,
  input  logic [DATA_BITS-1:0] cfg_wr_data,
  output logic                 cfg_wr_ready,
  input  logic                 clr_start,
  output logic                 clr_busy,
  output logic                 clr_done,
  input  logic                 lkup_req_valid,
  input  logic [ADDR_BITS-1:0] lkup_req_addr,
  output logic                 lkup_rsp_valid,
  output logic [DATA_BITS-1:0] lkup_rsp_data,
  output logic [ADDR_BITS-1:0] ram_addra,
  output logic [DATA_BITS-1:0] ram_dina,
  output logic                 ram_ena,
  output logic                 ram_wea,
  output logic [ADDR_BITS-1:0] ram_addrb,
  output logic                 ram_enb,
  input  logic [DATA_BITS-1:0] ram_doutb
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef enum logic {
    RR_CFG = 1'b0,
    RR_CLR = 1'b1
  } rr_e;

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_BITS-1:0] CNT_ONE   = {{(ADDR_BITS-1){1'b0}}, 1'b1};

  state_e                 state_q, state_d;
  rr_e                    rr_q, rr_d;
  logic [ADDR_BITS-1:0]   cnt_q, cnt_d;
  logic                   cfg_ready_s;
  logic                   cfg_fire_s;
  logic                   clr_fire_s;

  // Write-port FSM next state and port-A slot arbitration
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    cfg_ready_s = 1'b1;
    cfg_fire_s  = 1'b0;
    clr_fire_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cfg_ready_s = 1'b1;
        cfg_fire_s  = cfg_wr_valid;
        if (clr_start) begin
          state_d = ST_CLEAR;
          rr_d    = RR_CFG;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        // Ready follows the round-robin pointer only; an idle cfg slot goes to the clear.
        cfg_ready_s = (rr_q == RR_CFG);
        if ((rr_q == RR_CFG) && cfg_wr_valid) begin
          cfg_fire_s = 1'b1;
          rr_d       = RR_CLR;
        end else begin
          clr_fire_s = 1'b1;
          rr_d       = RR_CFG;
          cnt_d      = cnt_q + CNT_ONE;
          if (cnt_q == LAST_ADDR) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_CLEAR;
          end
        end
      end
      ST_DONE: begin
        cfg_ready_s = 1'b1;
        cfg_fire_s  = cfg_wr_valid;
        state_d     = ST_IDLE;
      end
      default: begin
        cfg_ready_s = 1'b0;
        state_d     = ST_IDLE;
        rr_d        = RR_CFG;
        cnt_d       = '0;
      end
    endcase
  end

  // Write-port FSM state, pointer and clear counter
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      rr_q    <= RR_CFG;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Port-A mux: clear engine or config pass-through
  always_comb begin
    if (clr_fire_s) begin
      ram_addra = cnt_q;
      ram_dina  = CLR_VALUE;
    end else begin
      ram_addra = cfg_wr_addr;
      ram_dina  = cfg_wr_data;
    end
  end

  assign ram_ena      = cfg_fire_s | clr_fire_s;
  assign ram_wea      = cfg_fire_s | clr_fire_s;
  assign cfg_wr_ready = cfg_ready_s;
  assign clr_busy     = (state_q == ST_CLEAR);
  assign clr_done     = (state_q == ST_DONE);

  assign ram_enb   = lkup_req_valid;
  assign ram_addrb = lkup_req_addr;

  logic [RD_LAT-1:0]    vld_q;
  logic [RD_LAT:0]      vld_shift_s;
  logic [DATA_BITS-1:0] rsp_src_s;
  logic [DATA_BITS-1:0] rsp_hold_q;

  assign vld_shift_s = {vld_q, lkup_req_valid};

  // Read-valid pipeline matching the RAM port-B latency
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_shift_s[RD_LAT-1:0];
    end
  end

`ifdef LKUP_WR_BYPASS_EN
  logic [RD_LAT-1:0]    hit_q;
  logic [RD_LAT:0]      hit_shift_s;
  logic                 hit_now_s;
  logic [DATA_BITS-1:0] byp_s [RD_LAT+1];
  logic [DATA_BITS-1:0] byp_q [RD_LAT];

  // Only a write in the request cycle itself is forwarded; later writes are not.
  assign hit_now_s   = lkup_req_valid & ram_ena & ram_wea & (ram_addra == lkup_req_addr);
  assign hit_shift_s = {hit_q, hit_now_s};

  // Bypass data pipeline input taps
  always_comb begin
    byp_s[0] = ram_dina;
    for (int i = 0; i < RD_LAT; i++) begin
      byp_s[i+1] = byp_q[i];
    end
  end

  // Bypass hit flag and data pipeline
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      hit_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        byp_q[i] <= '0;
      end
    end else begin
      hit_q <= hit_shift_s[RD_LAT-1:0];
      for (int i = 0; i < RD_LAT; i++) begin
        byp_q[i] <= byp_s[i];
      end
    end
  end

  // Response source: forwarded write data or RAM output
  always_comb begin
    if (hit_q[RD_LAT-1]) begin
      rsp_src_s = byp_q[RD_LAT-1];
    end else begin
      rsp_src_s = ram_doutb;
    end
  end
`else
  assign rsp_src_s = ram_doutb;
`endif

  // Last delivered response, held while no response is valid
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rsp_hold_q <= '0;
    end else if (vld_q[RD_LAT-1]) begin
      rsp_hold_q <= rsp_src_s;
    end else begin
      rsp_hold_q <= rsp_hold_q;
    end
  end

  assign lkup_rsp_valid = vld_q[RD_LAT-1];

  // Response data: live source when valid, otherwise the held value
  always_comb begin
    if (vld_q[RD_LAT-1]) begin
      lkup_rsp_data = rsp_src_s;
    end else begin
      lkup_rsp_data = rsp_hold_q;
    end
  end

endmodule
